// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and slave address map for the APB initiator
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    localparam int NSLAVES = 3;
    localparam logic [31:0] SLV_BASE  [NSLAVES] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
    localparam logic [31:0] SLV_LIMIT [NSLAVES] = '{32'h83FF_FFFF, 32'h87FF_FFFF, 32'h8BFF_FFFF};
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: byte address to one-hot slave select plus a miss flag
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NSLAVES-1:0] sel,
    output logic               miss
);
    // each slave claims its inclusive base..limit window
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSLAVES; i++)
            sel[i] = addr >= ADDR_W'(SLV_BASE[i]) && addr <= ADDR_W'(SLV_LIMIT[i]);
    end
    assign miss = ~|sel;
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-command APB initiator with SETUP/ACCESS sequencing and one-cycle responses
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [NSLAVES-1:0] Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  PWdata,
    input  logic [DATA_W-1:0]  PRdata
);
    apb_state_t state, state_n;
    logic [NSLAVES-1:0] sel;
    logic miss, acc, rdy_q, pend;

    apb_addr_decode #(.ADDR_W(ADDR_W)) u_dec (.addr(cmd_addr), .sel(sel), .miss(miss));

    assign cmd_ready = rdy_q && state != SETUP;
    assign acc = cmd_valid && cmd_ready;

    // state register; rdy_q keeps cmd_ready low until the first edge after reset
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= 1'b1;
        end
    end

    // SETUP always advances; otherwise an accepted hit starts a transfer
    always_comb begin
        state_n = state;
        state_n = (state == SETUP) ? ACCESS : (acc && !miss) ? SETUP : IDLE;
    end

    // APB bus registers: load on hit, strobe in ACCESS, release select after ACCESS
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= '0;
            PWdata  <= '0;
        end else if (acc && !miss) begin
            Pselx   <= sel;
            Penable <= 1'b0;
            Pwrite  <= cmd_write;
            Paddr   <= cmd_addr;
            PWdata  <= cmd_wdata;
        end else if (state == SETUP) begin
            Penable <= 1'b1;
        end else if (state == ACCESS) begin
            Pselx   <= '0;
            Penable <= 1'b0;
        end
    end

    // responses: a finishing transfer wins, a colliding miss waits one cycle in pend
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            pend      <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= Pwrite ? '0 : PRdata;
            pend      <= acc && miss;
        end else begin
            rsp_valid <= pend || (acc && miss);
            rsp_err   <= pend || (acc && miss);
            rsp_rdata <= '0;
            pend      <= pend && acc && miss;
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: table-driven and scoreboard checks of the APB initiator
module tb_apb_master_ctrl;
    logic        Hclk = 1'b0, Hresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, prdata_val = '0;
    logic        cmd_ready, rsp_valid, rsp_err, Penable, Pwrite;
    logic [31:0] rsp_rdata, Paddr, PWdata, PRdata;
    logic [2:0]  Pselx;

    typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;
    typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic [31:0] rd; logic [2:0] sel;} vec_t;

    rsp_t q[$];
    vec_t v[8];
    int checks = 0, failures = 0;

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .PWdata(PWdata), .PRdata(PRdata)
    );

    always #5 Hclk = ~Hclk;

    // slave model: valid read data only during a read ACCESS phase
    assign PRdata = (Penable && !Pwrite) ? prdata_val : 32'hFFFF_FFFF;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge Hclk);
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    // scoreboard monitor
    always @(negedge Hclk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_err, rsp_rdata}, 64'hDEAD);
            end else begin
                rsp_t e;
                e = q.pop_front();
                chk("rsp_sb", {31'd0, rsp_err, rsp_rdata}, {31'd0, e.err, e.rdata});
            end
        end
    end

    initial begin
        v[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         3'b001};
        v[1] = '{1'b0, 32'h8400_0004, 32'h0,         32'h1234_5678, 3'b010};
        v[2] = '{1'b0, 32'h8BFF_FFFC, 32'h0,         32'hCAFE_F00D, 3'b100};
        v[3] = '{1'b1, 32'h87FF_FFFF, 32'h0BAD_CAFE, 32'h0,         3'b010};
        v[4] = '{1'b0, 32'h9000_0000, 32'h0,         32'h1111_1111, 3'b000};
        v[5] = '{1'b1, 32'h7FFF_FFFF, 32'h2222_2222, 32'h0,         3'b000};
        v[6] = '{1'b0, 32'h8C00_0000, 32'h0,         32'h3333_3333, 3'b000};
        v[7] = '{1'b0, 32'h8800_0000, 32'h0,         32'hA5A5_5A5A, 3'b100};

        repeat (3) @(negedge Hclk);
        chk("reset_outs", {Pselx, Penable, Pwrite, rsp_valid, rsp_err, cmd_ready}, 64'd0);
        chk("reset_paddr", Paddr, 64'd0);
        chk("reset_pwdata", PWdata, 64'd0);
        chk("reset_rdata", rsp_rdata, 64'd0);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        chk("ready_after_reset", cmd_ready, 64'd1);

        for (int i = 0; i < 8; i++) begin
            @(negedge Hclk);
            prdata_val = v[i].rd; cmd_write = v[i].w; cmd_addr = v[i].a; cmd_wdata = v[i].d; cmd_valid = 1'b1;
            chk($sformatf("v%0d_ready", i), cmd_ready, 64'd1);
            @(posedge Hclk);
            q.push_back({v[i].sel == 3'b000, (v[i].w || v[i].sel == 3'b000) ? 32'h0 : v[i].rd});
            #1 cmd_valid = 1'b0;
            @(negedge Hclk);
            if (v[i].sel != 3'b000) begin
                chk($sformatf("v%0d_setup", i), {Pselx, Penable, Pwrite, cmd_ready}, {58'd0, v[i].sel, 1'b0, v[i].w, 1'b0});
                chk($sformatf("v%0d_paddr", i), Paddr, {32'd0, v[i].a});
                if (v[i].w) chk($sformatf("v%0d_pwdata", i), PWdata, {32'd0, v[i].d});
                @(negedge Hclk);
                chk($sformatf("v%0d_access", i), {Pselx, Penable, Pwrite, cmd_ready}, {58'd0, v[i].sel, 1'b1, v[i].w, 1'b1});
                chk($sformatf("v%0d_paddr_hold", i), Paddr, {32'd0, v[i].a});
                @(negedge Hclk);
                chk($sformatf("v%0d_rsp", i), {rsp_valid, Pselx, Penable}, {59'd0, 1'b1, 3'b000, 1'b0});
            end else begin
                chk($sformatf("v%0d_miss", i), {rsp_valid, rsp_err, Pselx, Penable}, {58'd0, 1'b1, 1'b1, 3'b000, 1'b0});
            end
            @(negedge Hclk);
            chk($sformatf("v%0d_rsp_end", i), rsp_valid, 64'd0);
            drain();
        end

        // back-to-back read then write with cmd_valid held
        @(negedge Hclk);
        prdata_val = 32'h0F0E_0D0C; cmd_write = 1'b0; cmd_addr = 32'h8800_0000; cmd_valid = 1'b1;
        @(posedge Hclk);
        q.push_back({1'b0, 32'h0F0E_0D0C});
        #1 cmd_write = 1'b1; cmd_addr = 32'h8000_0000; cmd_wdata = 32'h5555_AAAA;
        @(negedge Hclk);
        chk("b2b_setup1", {Pselx, Penable, cmd_ready}, {59'd0, 3'b100, 1'b0, 1'b0});
        @(negedge Hclk);
        chk("b2b_access1", {Pselx, Penable, cmd_ready}, {59'd0, 3'b100, 1'b1, 1'b1});
        @(posedge Hclk);
        q.push_back({1'b0, 32'h0});
        #1 cmd_valid = 1'b0;
        @(negedge Hclk);
        chk("b2b_setup2", {Pselx, Penable, cmd_ready, rsp_valid, Pwrite}, {57'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1});
        chk("b2b_pwdata", PWdata, 64'h5555_AAAA);
        @(negedge Hclk);
        chk("b2b_access2", {Pselx, Penable, cmd_ready, rsp_valid}, {58'd0, 3'b001, 1'b1, 1'b1, 1'b0});
        @(negedge Hclk);
        chk("b2b_done", {Pselx, Penable, rsp_valid}, {59'd0, 3'b000, 1'b0, 1'b1});
        drain();

        // miss accepted during ACCESS: two ordered responses
        @(negedge Hclk);
        prdata_val = 32'h7777_1111; cmd_write = 1'b0; cmd_addr = 32'h8000_0020; cmd_valid = 1'b1;
        @(posedge Hclk);
        q.push_back({1'b0, 32'h7777_1111});
        #1 cmd_addr = 32'h9000_0000;
        @(negedge Hclk);
        chk("mia_setup_ready", cmd_ready, 64'd0);
        @(negedge Hclk);
        chk("mia_access", {Penable, cmd_ready}, 64'd3);
        @(posedge Hclk);
        q.push_back({1'b1, 32'h0});
        #1 cmd_valid = 1'b0;
        @(negedge Hclk);
        chk("mia_rsp1", {rsp_valid, rsp_err, Pselx, Penable}, {58'd0, 1'b1, 1'b0, 3'b000, 1'b0});
        chk("mia_rdata1", rsp_rdata, 64'h7777_1111);
        @(negedge Hclk);
        chk("mia_rsp2", {rsp_valid, rsp_err}, 64'd3);
        chk("mia_rdata2", rsp_rdata, 64'd0);
        @(negedge Hclk);
        chk("mia_end", rsp_valid, 64'd0);
        drain();

        // reset during ACCESS of a read
        @(negedge Hclk);
        prdata_val = 32'h2222_3333; cmd_write = 1'b0; cmd_addr = 32'h8400_0008; cmd_valid = 1'b1;
        @(posedge Hclk);
        q.push_back({1'b0, 32'h2222_3333});
        #1 cmd_valid = 1'b0;
        @(negedge Hclk);
        @(negedge Hclk);
        chk("rst_pre_access", {Pselx, Penable}, {59'd0, 3'b010, 1'b1});
        Hresetn = 1'b0;
        #1;
        chk("rst_async_outs", {Pselx, Penable, Pwrite, rsp_valid, cmd_ready}, 64'd0);
        chk("rst_async_paddr", Paddr, 64'd0);
        void'(q.pop_back());
        repeat (3) begin
            @(negedge Hclk);
            chk("rst_no_rsp", rsp_valid, 64'd0);
        end
        Hresetn = 1'b1;
        chk("rst_ready_low", cmd_ready, 64'd0);
        @(posedge Hclk); #1;
        chk("rst_ready_back", cmd_ready, 64'd1);
        @(negedge Hclk);
        cmd_write = 1'b1; cmd_addr = 32'h8000_0000; cmd_wdata = 32'h1357_9BDF; cmd_valid = 1'b1;
        @(posedge Hclk);
        q.push_back({1'b0, 32'h0});
        #1 cmd_valid = 1'b0;
        @(negedge Hclk);
        chk("post_rst_setup", {Pselx, Penable, Pwrite}, {59'd0, 3'b001, 1'b0, 1'b1});
        chk("post_rst_pwdata", PWdata, 64'h1357_9BDF);
        drain();

        // idle
        repeat (10) begin
            @(negedge Hclk);
            chk("idle", {Pselx, Penable, rsp_valid}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
